// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ requesters.
// Latches the granted word, pulses send, then tracks tx_busy until the frame ends.
module uart_tx_arbiter #(
    parameter int WORD_LENGHT   = 8,
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WORD_LENGHT-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_mask,
    input  logic                           tx_busy,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [WORD_LENGHT-1:0]         TX_in,
    output logic                           send,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           active,
    output logic                           frame_done,
    output logic                           start_error
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]             state;
    logic [ID_W-1:0]        last;
    logic [ID_W-1:0]        pick;
    logic [ID_W:0]          sum;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_REQ-1:0]     eligible;
    logic                   found;
    logic [WORD_LENGHT-1:0] word;

    assign eligible = req_valid & req_mask;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!found && eligible[sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (pick == ID_W'(k))
                word = req_data[k*WORD_LENGHT +: WORD_LENGHT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= ID_W'(NUM_REQ-1);
            cnt         <= '0;
            req_ack     <= '0;
            TX_in       <= '0;
            send        <= 1'b0;
            grant_id    <= '0;
            active      <= 1'b0;
            frame_done  <= 1'b0;
            start_error <= 1'b0;
        end else begin
            req_ack     <= '0;
            send        <= 1'b0;
            frame_done  <= 1'b0;
            start_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        TX_in    <= word;
                        grant_id <= pick;
                        last     <= pick;
                        req_ack  <= NUM_REQ'(1) << pick;
                        send     <= 1'b1;
                        active   <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(START_TIMEOUT-1)) begin
                        start_error <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        active     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, timeout, rotation, masking,
// mid-frame reset and a request arriving as the frame ends.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    wire         tx_busy;
    logic [3:0]  req_ack;
    logic [7:0]  TX_in;
    logic        send;
    logic [1:0]  grant_id;
    logic        active;
    logic        frame_done;
    logic        start_error;

    logic        uart_en;
    logic        tx_busy_man;
    int          ph;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  words [4];

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_mask    (req_mask),
        .tx_busy     (tx_busy),
        .req_ack     (req_ack),
        .TX_in       (TX_in),
        .send        (send),
        .grant_id    (grant_id),
        .active      (active),
        .frame_done  (frame_done),
        .start_error (start_error)
    );

    // UART model: busy rises 3 cycles after send and stays high 10 cycles.
    always @(posedge clk) begin
        if (!uart_en)
            ph <= 0;
        else if (send)
            ph <= 1;
        else if (ph != 0 && ph < 13)
            ph <= ph + 1;
        else
            ph <= 0;
    end

    assign tx_busy = uart_en ? (ph >= 3 && ph <= 12) : tx_busy_man;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_send(output int n);
        n = 0;
        while (!send && n < 40) begin
            step();
            n++;
        end
        chk("send_seen", int'(send), 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_done && n < 40);
        chk("done_seen", int'(frame_done), 1);
    endtask

    initial begin
        int n;
        int cnt;
        int exp_id [5] = '{0, 1, 2, 3, 0};

        words = '{8'hA5, 8'h5A, 8'h96, 8'h3C};
        req_data    = {words[3], words[2], words[1], words[0]};
        rst         = 1'b1;
        req_valid   = 4'b1111;
        req_mask    = 4'b1111;
        uart_en     = 1'b0;
        tx_busy_man = 1'b0;

        step();
        step();
        chk("rst_ack", int'(req_ack), 0);
        chk("rst_send", int'(send), 0);
        chk("rst_tx", int'(TX_in), 0);
        chk("rst_gid", int'(grant_id), 0);
        chk("rst_act", int'(active), 0);
        chk("rst_flags", int'({frame_done, start_error}), 0);
        rst = 1'b0;

        step();
        chk("g0_ack", int'(req_ack), 1);
        chk("g0_send", int'(send), 1);
        chk("g0_tx", int'(TX_in), 32'hA5);
        chk("g0_act", int'(active), 1);
        req_valid = 4'b0000;

        // No busy ever: timeout 16 cycles after entering WAIT_BUSY.
        step();
        chk("to_wait_act", int'(active), 1);
        cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (start_error || frame_done) cnt++;
        end
        chk("to_early", cnt, 0);
        step();
        chk("to_err", int'(start_error), 1);
        chk("to_act", int'(active), 0);
        chk("to_nodone", int'(frame_done), 0);
        step();
        chk("to_err_w", int'(start_error), 0);

        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b1111;
        uart_en   = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_send(n);
            if (f > 0) chk("rr_gap", n, 0);
            chk("rr_gid", int'(grant_id), exp_id[f]);
            chk("rr_ack", int'(req_ack), 1 << exp_id[f]);
            chk("rr_tx", int'(TX_in), int'(words[exp_id[f]]));
            if (f == 4) req_valid = 4'b0000;
            wait_done(n);
            chk("rr_len", n, 14);
            step();
            chk("rr_fd_w", int'(frame_done), 0);
        end
        chk("rr_idle", int'(send), 0);

        req_valid = 4'b1010;
        req_mask  = 4'b1101;
        wait_send(n);
        chk("mk_gid", int'(grant_id), 3);
        chk("mk_ack", int'(req_ack), 32'h8);
        chk("mk_tx", int'(TX_in), 32'h3C);
        req_valid = 4'b0010;
        wait_done(n);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (req_ack != 4'b0000) cnt++;
        end
        chk("mk_none", cnt, 0);
        req_mask = 4'b1111;
        wait_send(n);
        chk("mk1_gid", int'(grant_id), 1);
        chk("mk1_ack", int'(req_ack), 32'h2);
        chk("mk1_tx", int'(TX_in), 32'h5A);
        req_valid = 4'b0000;

        // Reset while the frame is in WAIT_DONE.
        n = 0;
        while (!tx_busy && n < 20) begin
            step();
            n++;
        end
        chk("mr_busy", int'(tx_busy), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_act", int'(active), 0);
        chk("mr_fd", int'(frame_done), 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (frame_done || start_error || active) cnt++;
        end
        chk("mr_quiet", cnt, 0);
        req_valid = 4'b1111;
        step();
        chk("mr_gid", int'(grant_id), 0);
        chk("mr_ack", int'(req_ack), 1);
        req_valid = 4'b0000;
        wait_done(n);
        step();

        // Request rises on the edge where busy falls.
        uart_en   = 1'b0;
        req_valid = 4'b0100;
        step();
        chk("sm_gid", int'(grant_id), 2);
        chk("sm_send", int'(send), 1);
        req_valid   = 4'b0000;
        tx_busy_man = 1'b1;
        step();
        step();
        step();
        chk("sm_act", int'(active), 1);
        tx_busy_man = 1'b0;
        req_valid   = 4'b0001;
        step();
        chk("sm_fd", int'(frame_done), 1);
        chk("sm_nosend", int'(send), 0);
        chk("sm_idle", int'(active), 0);
        step();
        req_valid = 4'b0000;
        chk("sm_send2", int'(send), 1);
        chk("sm_ack2", int'(req_ack), 1);
        chk("sm_fd_w", int'(frame_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
